// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a parallel word as start/data/[parity]/stop and drives the line register.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle (tx=1), waiting for start
// START  | start bit (tx=0) on the line
// DATA   | payload bits on the line, LSB first
// PARITY | even parity of the captured word on the line (parity builds only)
// STOP   | stop bit (tx=1) on the line; done in its last cycle
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  reg_enb,
  output logic                  reg_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  boundary;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      parity_bit <= 1'b0;
    else if (state == IDLE && start)
      parity_bit <= ^data_in;
  end
`endif

  assign boundary = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      shift <= shift_next;
      if (state == IDLE || boundary)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      // tx only ever moves on a reg_enb pulse, i.e. on a bit boundary
      if (reg_enb)
        tx <= reg_in;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shift_next = shift;
    reg_enb    = 1'b0;
    reg_in     = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          reg_enb    = 1'b1;
          reg_in     = 1'b0;
          shift_next = data_in;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (boundary) begin
          reg_enb    = 1'b1;
          reg_in     = shift[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (boundary) begin
          reg_enb = 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            reg_in     = parity_bit;
            state_next = PARITY;
`else
            reg_in     = 1'b1;
            state_next = STOP;
`endif
          end else begin
            shift_next = shift >> 1;
            idx_next   = idx + IDX_W'(1);
            reg_in     = shift_next[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (boundary) begin
          reg_enb    = 1'b1;
          reg_in     = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (boundary) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Parity scenarios are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int FLEN = NB * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data_in;
  logic          reg_enb, reg_in, tx, busy, done;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .reg_enb (reg_enb),
    .reg_in  (reg_in),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_enb"}, reg_enb, 0);
  endtask

  // smode: 0 = start low during frame, 1 = start held high, 2 = start toggles every clk
  task automatic run_frame(input logic [DW-1:0] d, input int smode, input logic [DW-1:0] d_mid);
    logic exp_bits [NB];
    int   enb_cnt;
    int   done_cnt;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) exp_bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[DW+1] = ^d;
`endif
    exp_bits[NB-1] = 1'b1;

    start   = 1'b1;
    data_in = d;
    #1;
    check("accept_enb", reg_enb, 1);
    check("accept_in", reg_in, 0);
    check("accept_tx_idle", tx, 1);
    tick();
    enb_cnt  = 1;
    done_cnt = 0;
    for (int c = 1; c <= FLEN; c++) begin
      start   = (smode == 0) ? 1'b0 : (smode == 1) ? 1'b1 : c[0];
      data_in = (c >= 10) ? d_mid : d;
      #1;
      check("frame_tx", tx, exp_bits[(c-1)/CPB]);
      check("frame_busy", busy, 1);
      check("frame_done", done, (c == FLEN));
      if (reg_enb) enb_cnt++;
      if (done) done_cnt++;
      tick();
    end
    check("enb_pulses", enb_cnt, NB);
    check("done_pulses", done_cnt, 1);
    check("gap_busy", busy, 0);
    check("gap_tx", tx, 1);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_reg_in", reg_in, 1);
    rst = 1'b1;

    // quiet line after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("quiet");
    end

    run_frame(8'hA5, 0, 8'hA5);
    tick();

    // start held high: back-to-back frames, mid-frame data change ignored
    run_frame(8'h00, 1, 8'hFF);
    run_frame(8'hFF, 0, 8'h00);
    start = 1'b0;
    tick();

    // start toggling throughout a frame: one frame only, nothing queued
    run_frame(8'h5A, 2, 8'h5A);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle("after_toggle");
    end

    // reset in clk 17 of a frame (data bit 3 of 8'hC3 = 0 on the line)
    start   = 1'b1;
    data_in = 8'hC3;
    tick();
    start = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    check("pre_abort_tx", tx, 0);
    check("pre_abort_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("abort");
    tick();
    tick();
    check_idle("abort_hold");
    rst = 1'b1;
    tick();
    check_idle("post_abort");
    run_frame(8'h3C, 0, 8'h3C);

`ifdef UART_TX_PARITY_EN
    tick();
    run_frame(8'h07, 0, 8'h07);
    tick();
    run_frame(8'h03, 0, 8'h03);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
